// File: rtl/multicycle_control.sv
// Multi-cycle control FSM for the 16-bit TSC CPU: sequences IF/ID/EX/MEM/WB/HALT and decodes datapath strobes.
// Optional MC_INST_COUNT_EN builds the retired-instruction counter; otherwise num_inst_o is tied to zero.
module multicycle_control #(
  parameter int STATE_W = 3
) (
  input  logic        clk_i,
  input  logic        reset_i,
  input  logic [3:0]  opcode_i,
  input  logic [5:0]  func_i,
  input  logic        bcond_i,
  input  logic        mem_ready_i,
  output logic [4:0]  alu_func_o,
  output logic        alu_src_a_o,
  output logic [2:0]  alu_src_b_o,
  output logic        pc_write_o,
  output logic        pc_write_cond_o,
  output logic        ir_write_o,
  output logic        mem_read_o,
  output logic        mem_write_o,
  output logic        reg_write_o,
  output logic        i_or_d_o,
  output logic [1:0]  pc_source_o,
  output logic [1:0]  reg_dst_o,
  output logic [1:0]  mem_to_reg_o,
  output logic        wwd_o,
  output logic        halted_o,
  output logic [15:0] num_inst_o
);

  localparam logic [4:0] ALU_ADD  = 5'd0;
  localparam logic [4:0] ALU_SUB  = 5'd1;
  localparam logic [4:0] ALU_AND  = 5'd2;
  localparam logic [4:0] ALU_OR   = 5'd3;
  localparam logic [4:0] ALU_NOT  = 5'd4;
  localparam logic [4:0] ALU_TCP  = 5'd5;
  localparam logic [4:0] ALU_LLS  = 5'd6;
  localparam logic [4:0] ALU_ARS  = 5'd7;
  localparam logic [4:0] ALU_LHI  = 5'd8;
  localparam logic [4:0] ALU_BNE  = 5'd9;
  localparam logic [4:0] ALU_BEQ  = 5'd10;
  localparam logic [4:0] ALU_BGZ  = 5'd11;
  localparam logic [4:0] ALU_BLZ  = 5'd12;
  localparam logic [4:0] ALU_ZERO = 5'd15;

  localparam logic [3:0] OP_BNE = 4'd0;
  localparam logic [3:0] OP_BEQ = 4'd1;
  localparam logic [3:0] OP_BGZ = 4'd2;
  localparam logic [3:0] OP_BLZ = 4'd3;
  localparam logic [3:0] OP_ADI = 4'd4;
  localparam logic [3:0] OP_ORI = 4'd5;
  localparam logic [3:0] OP_LHI = 4'd6;
  localparam logic [3:0] OP_LWD = 4'd7;
  localparam logic [3:0] OP_SWD = 4'd8;
  localparam logic [3:0] OP_JMP = 4'd9;
  localparam logic [3:0] OP_JAL = 4'd10;
  localparam logic [3:0] OP_RT  = 4'd15;

  localparam logic [5:0] FN_JPR = 6'd25;
  localparam logic [5:0] FN_JRL = 6'd26;
  localparam logic [5:0] FN_WWD = 6'd28;
  localparam logic [5:0] FN_HLT = 6'd29;

  localparam logic [2:0] SRCB_REGB = 3'd0;
  localparam logic [2:0] SRCB_ONE  = 3'd1;
  localparam logic [2:0] SRCB_SE   = 3'd2;
  localparam logic [2:0] SRCB_ZE   = 3'd3;
  localparam logic [2:0] SRCB_ZERO = 3'd4;

  localparam logic [1:0] PCS_ALU    = 2'd0;
  localparam logic [1:0] PCS_ALUOUT = 2'd1;
  localparam logic [1:0] PCS_JUMP   = 2'd2;
  localparam logic [1:0] PCS_REGA   = 2'd3;

  localparam logic [1:0] DST_RT = 2'd0;
  localparam logic [1:0] DST_RD = 2'd1;
  localparam logic [1:0] DST_R2 = 2'd2;

  localparam logic [1:0] M2R_ALUOUT = 2'd0;
  localparam logic [1:0] M2R_MDR    = 2'd1;
  localparam logic [1:0] M2R_PC     = 2'd2;

  typedef enum logic [STATE_W-1:0] {S_IF, S_ID, S_EX, S_MEM, S_WB, S_HALT} state_t;

  state_t     state_q, state_d;
  logic       retire;
  logic       is_rtype;
  logic [4:0] rtype_alu;

  assign is_rtype = (opcode_i == OP_RT) && (func_i[5:3] == 3'b000);

  always_comb begin
    case (func_i[2:0])
      3'd0:    rtype_alu = ALU_ADD;
      3'd1:    rtype_alu = ALU_SUB;
      3'd2:    rtype_alu = ALU_AND;
      3'd3:    rtype_alu = ALU_OR;
      3'd4:    rtype_alu = ALU_NOT;
      3'd5:    rtype_alu = ALU_TCP;
      3'd6:    rtype_alu = ALU_LLS;
      default: rtype_alu = ALU_ARS;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) state_q <= S_IF;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d         = state_q;
    retire          = 1'b0;
    alu_func_o      = ALU_ZERO;
    alu_src_a_o     = 1'b0;
    alu_src_b_o     = SRCB_REGB;
    pc_write_o      = 1'b0;
    pc_write_cond_o = 1'b0;
    ir_write_o      = 1'b0;
    mem_read_o      = 1'b0;
    mem_write_o     = 1'b0;
    reg_write_o     = 1'b0;
    i_or_d_o        = 1'b0;
    pc_source_o     = PCS_ALU;
    reg_dst_o       = DST_RT;
    mem_to_reg_o    = M2R_ALUOUT;
    wwd_o           = 1'b0;
    // Reset suppresses every strobe in the same cycle, abandoning any pending access.
    if (!reset_i) begin
      case (state_q)
        S_IF: begin
          mem_read_o  = 1'b1;
          alu_func_o  = ALU_ADD;
          alu_src_b_o = SRCB_ONE;
          if (mem_ready_i) begin
            ir_write_o = 1'b1;
            pc_write_o = 1'b1;
            state_d    = S_ID;
          end
        end
        S_ID: begin
          // ALUOut captures PC + sext(imm8) here for a later branch.
          alu_func_o  = ALU_ADD;
          alu_src_b_o = SRCB_SE;
          state_d     = S_IF;
          retire      = 1'b1;
          case (opcode_i)
            OP_BNE, OP_BEQ, OP_BGZ, OP_BLZ, OP_ADI, OP_ORI, OP_LHI, OP_LWD, OP_SWD: begin
              state_d = S_EX;
              retire  = 1'b0;
            end
            OP_JMP: begin
              pc_write_o  = 1'b1;
              pc_source_o = PCS_JUMP;
            end
            OP_JAL: begin
              pc_write_o   = 1'b1;
              pc_source_o  = PCS_JUMP;
              reg_write_o  = 1'b1;
              reg_dst_o    = DST_R2;
              mem_to_reg_o = M2R_PC;
            end
            OP_RT: begin
              if (is_rtype) begin
                state_d = S_EX;
                retire  = 1'b0;
              end else begin
                case (func_i)
                  FN_JPR: begin
                    pc_write_o  = 1'b1;
                    pc_source_o = PCS_REGA;
                  end
                  FN_JRL: begin
                    pc_write_o   = 1'b1;
                    pc_source_o  = PCS_REGA;
                    reg_write_o  = 1'b1;
                    reg_dst_o    = DST_R2;
                    mem_to_reg_o = M2R_PC;
                  end
                  FN_WWD:  wwd_o = 1'b1;
                  FN_HLT:  state_d = S_HALT;
                  default: ;
                endcase
              end
            end
            default: ;
          endcase
        end
        S_EX: begin
          alu_src_a_o = 1'b1;
          state_d     = S_IF;
          case (opcode_i)
            OP_BNE, OP_BEQ, OP_BGZ, OP_BLZ: begin
              case (opcode_i)
                OP_BNE:  alu_func_o = ALU_BNE;
                OP_BEQ:  alu_func_o = ALU_BEQ;
                OP_BGZ:  alu_func_o = ALU_BGZ;
                default: alu_func_o = ALU_BLZ;
              endcase
              alu_src_b_o     = (opcode_i[1]) ? SRCB_ZERO : SRCB_REGB;
              pc_write_cond_o = 1'b1;
              pc_source_o     = PCS_ALUOUT;
              retire          = 1'b1;
            end
            OP_ADI: begin
              alu_func_o  = ALU_ADD;
              alu_src_b_o = SRCB_SE;
              state_d     = S_WB;
            end
            OP_ORI: begin
              alu_func_o  = ALU_OR;
              alu_src_b_o = SRCB_ZE;
              state_d     = S_WB;
            end
            OP_LHI: begin
              alu_func_o  = ALU_LHI;
              alu_src_b_o = SRCB_ZE;
              state_d     = S_WB;
            end
            OP_LWD, OP_SWD: begin
              alu_func_o  = ALU_ADD;
              alu_src_b_o = SRCB_SE;
              state_d     = S_MEM;
            end
            OP_RT: begin
              if (is_rtype) begin
                alu_func_o  = rtype_alu;
                alu_src_b_o = SRCB_REGB;
                state_d     = S_WB;
              end
            end
            default: ;
          endcase
        end
        S_MEM: begin
          i_or_d_o = 1'b1;
          if (opcode_i == OP_LWD) begin
            mem_read_o = 1'b1;
            if (mem_ready_i) state_d = S_WB;
          end else if (opcode_i == OP_SWD) begin
            mem_write_o = 1'b1;
            if (mem_ready_i) begin
              state_d = S_IF;
              retire  = 1'b1;
            end
          end else begin
            state_d = S_IF;
          end
        end
        S_WB: begin
          reg_write_o  = 1'b1;
          reg_dst_o    = is_rtype ? DST_RD : DST_RT;
          mem_to_reg_o = (opcode_i == OP_LWD) ? M2R_MDR : M2R_ALUOUT;
          state_d      = S_IF;
          retire       = 1'b1;
        end
        S_HALT: state_d = S_HALT;
        default: state_d = S_IF;
      endcase
    end
  end

  assign halted_o = (state_q == S_HALT);

  // The datapath qualifies the PC load with bcond; the FSM only raises pc_write_cond.
  logic unused_bcond;
  assign unused_bcond = bcond_i;

`ifdef MC_INST_COUNT_EN
  logic [15:0] num_inst_q, num_inst_d;

  assign num_inst_d = retire ? num_inst_q + 16'd1 : num_inst_q;

  always_ff @(posedge clk_i) begin
    if (reset_i) num_inst_q <= 16'h0000;
    else         num_inst_q <= num_inst_d;
  end

  assign num_inst_o = num_inst_q;
`else
  logic unused_retire;
  assign unused_retire = retire;
  assign num_inst_o    = 16'h0000;
`endif

endmodule

// File: doc/multicycle_control.md
# multicycle_control

Multi-cycle control FSM for the 16-bit TSC CPU: the initiator side of the ALU interface. It sequences each instruction through fetch, decode, execute, memory and write-back states. It drives the ALU's 5-bit function code and operand selects, consumes the ALU's `bcond` result for conditional branches, and handshakes with memory on every fetch and load/store.

## Interface
- `STATE_W`, default 3: state register width.
- `clk`  in  1  system clock, all state updates on rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `opcode`  in  4  IR[15:12]; sampled in ID/EX/MEM/WB.
- `func`  in  6  IR[5:0]; meaningful when `opcode`=15.
- `bcond`  in  1  ALU branch result; sampled only in branch EX cycle.
- `mem_ready`  in  1  memory completes the current access this cycle.
- `alu_func`  out  5  ALU function code, ALU_* values from opcodes.v.
- `alu_src_a`  out  1  0=PC, 1=regA.
- `alu_src_b`  out  3  0=regB, 1=const 1, 2=sign-ext imm8, 3=zero-ext imm8, 4=const 0.
- `pc_write`, `pc_write_cond`, `ir_write`, `mem_read`, `mem_write`, `reg_write`  out  1 each  strobes.
- `i_or_d`  out  1  memory address: 0=PC, 1=ALUOut.
- `pc_source`  out  2  0=ALU result, 1=ALUOut, 2={PC[15:12],IR[11:0]}, 3=regA.
- `reg_dst`  out  2  0=rt, 1=rd, 2=r2.
- `mem_to_reg`  out  2  0=ALUOut, 1=MDR, 2=PC.
- `wwd`  out  1  output-port write strobe. `halted`  out  1  CPU stopped.
- `num_inst`  out  16  retired-instruction count.

## Operation
- States: IF, ID, EX, MEM, WB, HALT. Outputs are a decode of state/`opcode`/`func`/`mem_ready`. Default: every strobe 0, `alu_func`=ALU_ZERO.
- IF: `mem_read`=1, `i_or_d`=0; ALU_ADD, src_a=PC, src_b=1. On `mem_ready`: `ir_write`=1, `pc_write`=1, `pc_source`=0, go to ID; otherwise stay in IF.
- ID: ALU_ADD, src_a=PC, src_b=2 (branch target into ALUOut).
- Completion in ID, next IF:
  - JMP (9): `pc_write`, `pc_source`=2.
  - JAL (10): additionally `reg_write`, `reg_dst`=2, `mem_to_reg`=2.
  - JPR (15/25): `pc_source`=3.
  - JRL (15/26): `pc_source`=3 plus link as JAL.
  - WWD (15/28): `wwd`=1.
  - Undefined opcode/func: no strobes.
- HLT (15/29): ID goes to HALT. HALT holds `halted`=1 with no strobes until reset.
- Branches BNE/BEQ/BGZ/BLZ (0..3): ID→EX. EX: `alu_func`=ALU_BNE/BEQ/BGZ/BLZ, src_a=regA; src_b=0 for BNE/BEQ, 4 for BGZ/BLZ. Asserts `pc_write_cond`, `pc_source`=1; the PC loads iff `bcond`. Next IF.
- R-type ALU ops (func 0..7: ADD, SUB, AND, ORR, NOT, TCP, SHL, SHR) map to ALU_ADD, SUB, AND, OR, NOT, TCP, LLS, ARS. EX: src_a=1, src_b=0. WB: `reg_write`, `reg_dst`=1, `mem_to_reg`=0.
- ADI(4)/ORI(5)/LHI(6): EX with ALU_ADD src_b=2, ALU_OR src_b=3, ALU_LHI src_b=3 respectively. WB: `reg_dst`=0, `mem_to_reg`=0.
- LWD(7)/SWD(8): EX uses ALU_ADD, src_a=1, src_b=2.
  - MEM: `i_or_d`=1 with `mem_read` (LWD) or `mem_write` (SWD), held until `mem_ready`.
  - LWD: MEM→WB, WB asserts `reg_dst`=0, `mem_to_reg`=1.
  - SWD: MEM→IF.
- `num_inst` increments by 1, with 16-bit wrap, on the final cycle of each instruction: ready MEM for SWD, WB, ID completions, branch EX, and HLT's ID cycle.

## Timing
- Reset: while `reset`=1, every strobe is forced 0 the same cycle. Next state is IF, `halted`=0, `num_inst`=0.
- Reset mid-access (IF/MEM wait): the access is abandoned with no `ir_write`/`reg_write`. Fetch restarts the cycle after reset deasserts.
- Minimum latencies, zero memory wait: JMP/JAL/JPR/JRL/WWD 2 cycles; branch 3; R-type/immediate 4; SWD 4; LWD 5. Each memory wait cycle adds 1.
- `mem_ready` outside IF/MEM is ignored. `bcond` outside branch EX is ignored.
- Strobes (`ir_write`, `pc_write`, `reg_write`, `wwd`) are single-cycle pulses per instruction.

## Configuration
- `MC_INST_COUNT_EN` defined: `num_inst` is a live 16-bit counter as described.
- `MC_INST_COUNT_EN` undefined: no counter register is built and `num_inst` is tied to 16'h0000.

## Test plan
- Reset, then IR=0xF6C0 (ADD $3,$1,$2), `mem_ready`=1: state sequence IF,ID,EX,WB. In EX, `alu_func`=ALU_ADD, src_a=1, src_b=0. In WB, `reg_write`=1, `reg_dst`=1. `num_inst`=1.
- IR=0x1104 (BEQ $0,$1,+4) with `bcond`=1, then a second run with `bcond`=0: EX asserts `alu_func`=ALU_BEQ, `pc_write_cond`=1, `pc_source`=1 in both runs. Back in IF at cycle 4 in both.
- IR=0x7103 (LWD $1,3($0)), `mem_ready` low for 2 cycles in MEM: `mem_read`=1 and `i_or_d`=1 held for 3 cycles. Then WB asserts `mem_to_reg`=1, `reg_dst`=0. Total 7 cycles.
- IR=0xA123 (JAL): the ID cycle asserts `pc_write`, `pc_source`=2, `reg_write`, `reg_dst`=2, `mem_to_reg`=2. Next state IF.
- IR=0xF01D (HLT): HALT entered after ID, `halted`=1 and all strobes 0 for 10+ cycles. Asserting `reset` returns the FSM to IF with `halted`=0 and `num_inst`=0.
- `reset` pulsed while the FSM waits in SWD MEM: `mem_write` drops the same cycle and `num_inst` is unchanged by the aborted SWD. Build with `MC_INST_COUNT_EN` undefined and check `num_inst`=0 throughout.
